imm_ext_stage: RTL and testbench

Registered, parametrised immediate-extension stage for the decode pipeline. Takes an IN_W-bit immediate field plus a mode select and a sideband tag. Produces an OUT_W-bit extended operand: sign-extended, zero-extended, upper-loaded or branch-offset. A valid/ready handshake on both sides and a one-entry skid buffer let decode stall without losing an immediate, while keeping every control path registered.

---
 rtl/imm_ext_stage.sv | 138 +++++++++++++
 tb/tb_imm_ext_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_stage.sv
// imm_ext_stage
//
// Registered immediate-extension stage for the decode pipeline. An IN_W-bit
// immediate field is extended to OUT_W bits in one of four modes:
//   0 SEXT   : sign-extend
//   1 ZEXT   : zero-extend
//   2 UPPER  : immediate placed in the top IN_W bits, low bits zero
//   3 BRANCH : sign-extend, then shift left by BR_SHIFT (overflow discarded)
// The result and a sideband tag travel through one output register backed by
// a one-entry skid register. This keeps in_ready a pure register output while
// still allowing full throughput and loss-free stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream presents an immediate
//   in_ready   stage can accept (registered, equals NOT skid valid)
//   in_imm     raw immediate field, IN_W bits
//   in_mode    extension mode select (see above)
//   in_tag     sideband tag, carried unchanged
//   out_valid  out_imm/out_tag hold a valid result
//   out_ready  downstream accepts this cycle
//   out_imm    extended operand, OUT_W bits
//   out_tag    tag that travelled with the operand

module imm_ext_stage #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'd0,
        MODE_ZEXT   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } mode_e;

    localparam int PAD_W = OUT_W - IN_W;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        sext = {{PAD_W{imm[IN_W-1]}}, imm};
        case (mode_e'(mode))
            MODE_SEXT:  extend = sext;
            MODE_ZEXT:  extend = {{PAD_W{1'b0}}, imm};
            MODE_UPPER: extend = {imm, {PAD_W{1'b0}}};
            default:    extend = sext << BR_SHIFT;
        endcase
    endfunction

    // Output and skid registers.
    logic             out_valid_q,  out_valid_d;
    logic [OUT_W-1:0] out_imm_q,    out_imm_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    logic             in_xfer;
    logic [OUT_W-1:0] ext_val;

    assign in_ready = ~skid_valid_q;
    assign in_xfer  = in_valid & in_ready;
    assign ext_val  = extend(in_imm, in_mode);

    // Next-state selection, evaluated on current register state.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;

        if (skid_valid_q) begin
            // Skid full: in_ready is low, so only a drain can happen.
            if (out_ready) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_ready) begin
            // Output register is free (or being consumed this edge).
            if (in_xfer) begin
                out_valid_d = 1'b1;
                out_imm_d   = ext_val;
                out_tag_d   = in_tag;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // Output stalled: park the new entry in the skid.
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_val;
            skid_tag_d   = in_tag;
        end
    end

    // ---- register stage boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst;

    // Default-parameter instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;

    // Wide instance: IN_W=12, OUT_W=64, BR_SHIFT=1
    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_imm;
    logic [1:0]  b_in_mode;
    logic [4:0]  b_in_tag;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [63:0] b_out_imm;
    logic [4:0]  b_out_tag;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_ext_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag)
    );

    imm_ext_stage #(.IN_W(12), .OUT_W(64), .BR_SHIFT(1), .TAG_W(5)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_tag(b_out_tag)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    // Golden model for the default parameters, written out per mode.
    function automatic logic [31:0] gold(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (mode)
            2'd0:    gold = s;
            2'd1:    gold = {16'h0000, imm};
            2'd2:    gold = {imm, 16'h0000};
            default: gold = {s[29:0], 2'b00};
        endcase
    endfunction

    logic [31:0] qv[$];
    logic [4:0]  qt[$];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1'b1;

        // Reset state
        tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_imm",   64'(out_imm),   64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);

        // Mode coverage, back to back with out_ready high
        out_ready = 1'b1;
        drive(16'hFFF5, 2'd0, 5'd1); tick();
        check("sext_valid", 64'(out_valid), 64'd1);
        check("sext_fff5",  64'(out_imm), 64'hFFFFFFF5);
        check("sext_tag",   64'(out_tag), 64'd1);
        drive(16'hFFF5, 2'd1, 5'd2); tick();
        check("zext_fff5",  64'(out_imm), 64'h0000FFF5);
        drive(16'hFFF5, 2'd3, 5'd3); tick();
        check("br_fff5",    64'(out_imm), 64'hFFFFFFD4);
        drive(16'h1234, 2'd2, 5'd4); tick();
        check("upper_1234", 64'(out_imm), 64'h12340000);
        drive(16'd4, 2'd3, 5'd5); tick();
        check("br_4",       64'(out_imm), 64'h00000010);
        drive(16'd4, 2'd0, 5'd6); tick();
        check("sext_4",     64'(out_imm), 64'h00000004);
        check("sext_4_tag", 64'(out_tag), 64'd6);
        in_valid = 1'b0; tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Back-to-back streaming, tags 0..7
        for (int i = 0; i < 8; i++) begin
            drive(16'(i * 3), 2'd1, 5'(i));
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_tag",   64'(out_tag), 64'(i));
            check("stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0; tick();
        check("stream_end", 64'(out_valid), 64'd0);

        // Stall and skid
        out_ready = 1'b0;
        drive(16'h0011, 2'd1, 5'd1); tick();
        check("stall_t1", 64'(out_tag), 64'd1);
        check("stall_ready1", 64'(in_ready), 64'd1);
        drive(16'h0022, 2'd1, 5'd2); tick();
        check("stall_skid_ready", 64'(in_ready), 64'd0);
        drive(16'h0033, 2'd1, 5'd3); tick();
        check("stall_hold_tag", 64'(out_tag), 64'd1);
        check("stall_hold_imm", 64'(out_imm), 64'h11);
        check("stall_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1; tick();
        check("drain_t2", 64'(out_tag), 64'd2);
        check("drain_t2_imm", 64'(out_imm), 64'h22);
        check("drain_ready", 64'(in_ready), 64'd1);
        tick();
        check("drain_t3", 64'(out_tag), 64'd3);
        check("drain_t3_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0; tick();
        check("drain_empty", 64'(out_valid), 64'd0);

        // Reset mid-stall with both entries full
        out_ready = 1'b0;
        drive(16'h00AA, 2'd1, 5'd9);  tick();
        drive(16'h00BB, 2'd1, 5'd10); tick();
        check("pre_rst_ready", 64'(in_ready), 64'd0);
        drive(16'h00CC, 2'd1, 5'd11);
        rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_imm",   64'(out_imm), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // Parameter sweep on the wide instance
        b_in_valid = 1'b1; b_in_imm = 12'h800;
        b_in_mode = 2'd0; b_in_tag = 5'd1; tick();
        check("w_sext",  b_out_imm, 64'hFFFFFFFFFFFFF800);
        check("w_valid", 64'(b_out_valid), 64'd1);
        b_in_mode = 2'd1; b_in_tag = 5'd2; tick();
        check("w_zext",  b_out_imm, 64'h0000000000000800);
        b_in_mode = 2'd3; b_in_tag = 5'd3; tick();
        check("w_branch", b_out_imm, 64'hFFFFFFFFFFFFF000);
        b_in_mode = 2'd2; b_in_tag = 5'd4; tick();
        check("w_upper", b_out_imm, 64'h8000000000000000);
        check("w_tag",   64'(b_out_tag), 64'd4);
        b_in_valid = 1'b0;

        // Randomised valid/ready against a queue model
        begin
            int sent = 0;
            int rcvd = 0;
            int cyc  = 0;
            logic        held;
            logic [31:0] hv;
            logic [4:0]  ht;
            in_valid = 1'b0; out_ready = 1'b1; tick();
            while (rcvd < 1000 && cyc < 20000) begin
                in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                in_imm    = 16'($urandom);
                in_mode   = 2'($urandom_range(0, 3));
                in_tag    = 5'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
                if (in_valid && in_ready) begin
                    qv.push_back(gold(in_imm, in_mode));
                    qt.push_back(in_tag);
                    sent++;
                end
                if (out_valid && out_ready) begin
                    if (qv.size() == 0) begin
                        check("rnd_spurious", 64'd1, 64'd0);
                    end else begin
                        check("rnd_imm", 64'(out_imm), 64'(qv.pop_front()));
                        check("rnd_tag", 64'(out_tag), 64'(qt.pop_front()));
                    end
                    rcvd++;
                end
                held = out_valid && !out_ready;
                hv   = out_imm;
                ht   = out_tag;
                tick();
                cyc++;
                if (held) begin
                    check("rnd_hold_valid", 64'(out_valid), 64'd1);
                    check("rnd_hold_imm",   64'(out_imm), 64'(hv));
                    check("rnd_hold_tag",   64'(out_tag), 64'(ht));
                end
            end
            check("rnd_count", 64'(rcvd), 64'd1000);
            check("rnd_leftover", 64'(qv.size()), 64'd0);
            in_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
